// File: rtl/comparator_bist.sv
// Self-test sequencer for the registered magnitude comparator: pulses its reset, sweeps every
// operand pair, checks the result flags and reports pass/fail, error count and first failing pair.
module comparator_bist #(
  parameter int unsigned WIDTH          = 2,
  parameter int unsigned RESULT_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic [WIDTH-1:0]     o_a,
  output logic [WIDTH-1:0]     o_b,
  output logic                 o_cmp_rst,
  input  logic                 i_a_gt_b_reg,
  input  logic                 i_a_eq_b_reg,
  input  logic                 i_a_lt_b_reg,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [2*WIDTH+1:0]   o_err_count,
  output logic [WIDTH-1:0]     o_fail_a,
  output logic [WIDTH-1:0]     o_fail_b
);

  localparam int unsigned      ErrW    = 2 * WIDTH + 2;
  localparam logic [2:0]       LastCnt = 3'(RESULT_LATENCY);
  localparam logic [WIDTH-1:0] MaxOp   = '1;

  typedef enum logic [2:0] {
    StIdle,
    StRstStep,
    StPairStep,
    StFinalRstStep,
    StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [2:0]       r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [WIDTH-1:0] r_fail_a, w_fail_a_d;
  logic [WIDTH-1:0] r_fail_b, w_fail_b_d;
  logic             r_cmp_rst, w_cmp_rst_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_pass, w_pass_d;
  logic [ErrW-1:0]  r_err, w_err_d;

  logic             w_step_end;
  logic             w_is_rst_step;
  logic             w_mismatch;
  logic [2:0]       w_flags;
  logic [2:0]       w_expect;

  assign w_flags       = {i_a_gt_b_reg, i_a_eq_b_reg, i_a_lt_b_reg};
  assign w_expect      = {r_a > r_b, r_a == r_b, r_a < r_b};
  assign w_step_end    = (r_cnt == LastCnt);
  assign w_is_rst_step = (r_state == StRstStep) || (r_state == StFinalRstStep);
  // A reset step expects all flags low; one error per step regardless of how many flags are set.
  assign w_mismatch    = w_is_rst_step ? (|w_flags) : (w_flags != w_expect);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_fail_a  <= '0;
      r_fail_b  <= '0;
      r_cmp_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_a       <= w_a_d;
      r_b       <= w_b_d;
      r_fail_a  <= w_fail_a_d;
      r_fail_b  <= w_fail_b_d;
      r_cmp_rst <= w_cmp_rst_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_pass    <= w_pass_d;
      r_err     <= w_err_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_a_d       = r_a;
    w_b_d       = r_b;
    w_fail_a_d  = r_fail_a;
    w_fail_b_d  = r_fail_b;
    w_cmp_rst_d = 1'b0;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_pass_d    = r_pass;
    w_err_d     = r_err;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d   = StRstStep;
          w_cnt_d     = '0;
          w_a_d       = '0;
          w_b_d       = '0;
          w_cmp_rst_d = 1'b1;
          w_busy_d    = 1'b1;
          w_pass_d    = 1'b0;
          w_err_d     = '0;
          w_fail_a_d  = '0;
          w_fail_b_d  = '0;
        end
      end
      StRstStep, StPairStep, StFinalRstStep: begin
        w_cnt_d = r_cnt + 3'd1;
        if (w_step_end) begin
          w_cnt_d = '0;
          if (w_mismatch) begin
            if (r_err != '1) w_err_d = r_err + ErrW'(1);
            // Only a pair failure records operands; a reset-check failure leaves them at 0.
            if ((r_err == '0) && (r_state == StPairStep)) begin
              w_fail_a_d = r_a;
              w_fail_b_d = r_b;
            end
          end
          if (r_state == StRstStep) begin
            w_state_d = StPairStep;
          end else if (r_state == StPairStep) begin
            if (r_b != MaxOp) begin
              w_b_d = r_b + WIDTH'(1);
            end else if (r_a != MaxOp) begin
              w_a_d = r_a + WIDTH'(1);
              w_b_d = '0;
            end else begin
              w_state_d   = StFinalRstStep;
              w_cmp_rst_d = 1'b1;
            end
          end else begin
            w_state_d = StDone;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
            w_pass_d  = (w_err_d == '0);
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_cmp_rst   = r_cmp_rst;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_fail_a    = r_fail_a;
  assign o_fail_b    = r_fail_b;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (latency 1 and 2) driving behavioural comparator
// models with injectable faults, checked every cycle against a run-timeline model.
module tb_comparator_bist;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic start    = 1'b0;
  logic cm_clear = 1'b1;
  logic chk_en   = 1'b0;
  int   sel      = 0;
  int   mode0    = 0;  // 0 good, 1 eq stuck 0, 2 ignores cmp_rst, 3 two-cycle output delay
  int   mode1    = 0;
  int   total    = 0;
  int   bad      = 0;

  always #5 clk = ~clk;

  logic [1:0] a0, b0, fa0, fb0, a1, b1, fa1, fb1;
  logic       cr0, busy0, done0, pass0, cr1, busy1, done1, pass1;
  logic [5:0] err0, err1;
  logic [2:0] flg0, flg1, c0_s1, c0_s2, c1_s1, c1_s2;

  comparator_bist #(.WIDTH(2), .RESULT_LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 0)),
    .o_a(a0), .o_b(b0), .o_cmp_rst(cr0),
    .i_a_gt_b_reg(flg0[2]), .i_a_eq_b_reg(flg0[1]), .i_a_lt_b_reg(flg0[0]),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_count(err0),
    .o_fail_a(fa0), .o_fail_b(fb0)
  );

  comparator_bist #(.WIDTH(2), .RESULT_LATENCY(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start && (sel == 1)),
    .o_a(a1), .o_b(b1), .o_cmp_rst(cr1),
    .i_a_gt_b_reg(flg1[2]), .i_a_eq_b_reg(flg1[1]), .i_a_lt_b_reg(flg1[0]),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
    .o_fail_a(fa1), .o_fail_b(fb1)
  );

  function automatic logic [2:0] cmpf(input logic [1:0] a, input logic [1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  // Comparator models; cm_clear stands in for power-up state.
  always @(posedge clk) begin
    if (cm_clear) begin
      c0_s1 <= 3'b000;
      c0_s2 <= 3'b000;
    end else begin
      if (cr0) begin
        if (mode0 != 2) c0_s1 <= 3'b000;
      end else begin
        c0_s1 <= cmpf(a0, b0);
      end
      c0_s2 <= c0_s1;
    end
  end

  always @(posedge clk) begin
    if (cm_clear) begin
      c1_s1 <= 3'b000;
      c1_s2 <= 3'b000;
    end else begin
      if (cr1) begin
        if (mode1 != 2) c1_s1 <= 3'b000;
      end else begin
        c1_s1 <= cmpf(a1, b1);
      end
      c1_s2 <= c1_s1;
    end
  end

  assign flg0 = ((mode0 == 3) ? c0_s2 : c0_s1) & ((mode0 == 1) ? 3'b101 : 3'b111);
  assign flg1 = ((mode1 == 3) ? c1_s2 : c1_s1) & ((mode1 == 1) ? 3'b101 : 3'b111);

  logic [1:0] s_a, s_b, s_fa, s_fb;
  logic       s_cr, s_busy, s_done, s_pass;
  logic [5:0] s_err;
  logic [2:0] s_flg;
  int         m_l, m_n;

  assign s_a    = (sel == 1) ? a1    : a0;
  assign s_b    = (sel == 1) ? b1    : b0;
  assign s_fa   = (sel == 1) ? fa1   : fa0;
  assign s_fb   = (sel == 1) ? fb1   : fb0;
  assign s_cr   = (sel == 1) ? cr1   : cr0;
  assign s_busy = (sel == 1) ? busy1 : busy0;
  assign s_done = (sel == 1) ? done1 : done0;
  assign s_pass = (sel == 1) ? pass1 : pass0;
  assign s_err  = (sel == 1) ? err1  : err0;
  assign s_flg  = (sel == 1) ? flg1  : flg0;
  assign m_l    = (sel == 1) ? 2 : 1;
  assign m_n    = 18 * (m_l + 1);

  // Run timeline: step 0 and step 17 are reset checks, steps 1..16 are pairs in sweep order.
  function automatic bit is_rst_k(input int k);
    return (k == 0) || (k == 17);
  endfunction
  function automatic logic [1:0] step_a(input int k);
    if (k == 0) return 2'd0;
    if (k == 17) return 2'd3;
    return 2'((k - 1) / 4);
  endfunction
  function automatic logic [1:0] step_b(input int k);
    if (k == 0) return 2'd0;
    if (k == 17) return 2'd3;
    return 2'((k - 1) % 4);
  endfunction
  function automatic logic [2:0] step_exp(input int k);
    if (is_rst_k(k)) return 3'b000;
    return cmpf(step_a(k), step_b(k));
  endfunction
  function automatic int end_k(input int t, input int l);
    return (t + 1) / (l + 1) - 1;
  endfunction

  int         m_t;     // cycles since the start edge; -1 when idle
  logic [5:0] m_err;
  logic       m_pass, m_hold;
  logic [1:0] m_fa, m_fb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= -1;
      m_err  <= 6'd0;
      m_pass <= 1'b0;
      m_hold <= 1'b0;
      m_fa   <= 2'd0;
      m_fb   <= 2'd0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t    <= 0;
        m_err  <= 6'd0;
        m_pass <= 1'b0;
        m_fa   <= 2'd0;
        m_fb   <= 2'd0;
      end
    end else if (m_t >= m_n) begin
      m_t <= -1;
    end else begin
      m_t <= m_t + 1;
      if ((m_t + 1) % (m_l + 1) == 0) begin
        if (s_flg !== step_exp(end_k(m_t, m_l))) begin
          if (m_err != 6'h3f) m_err <= m_err + 6'd1;
          if ((m_err == 6'd0) && !is_rst_k(end_k(m_t, m_l))) begin
            m_fa <= step_a(end_k(m_t, m_l));
            m_fb <= step_b(end_k(m_t, m_l));
          end
        end
        if (m_t + 1 == m_n) begin
          m_hold <= 1'b1;
          m_pass <= (m_err == 6'd0) && (s_flg === step_exp(end_k(m_t, m_l)));
        end
      end
    end
  end

  function automatic logic [1:0] exp_ab(input int t, input int l, input int n, input logic hold,
                                        input bit is_a);
    if (t < 0) return hold ? 2'd3 : 2'd0;
    if (t >= n) return 2'd3;
    return is_a ? step_a(t / (l + 1)) : step_b(t / (l + 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a",         32'(s_a),    32'(exp_ab(m_t, m_l, m_n, m_hold, 1'b1)));
      check("b",         32'(s_b),    32'(exp_ab(m_t, m_l, m_n, m_hold, 1'b0)));
      check("cmp_rst",   32'(s_cr),   32'((m_t >= 0) && (m_t < m_n) && (m_t % (m_l + 1) == 0)
                                            && is_rst_k(m_t / (m_l + 1))));
      check("busy",      32'(s_busy), 32'((m_t >= 0) && (m_t < m_n)));
      check("done",      32'(s_done), 32'(m_t == m_n));
      check("pass",      32'(s_pass), 32'(m_pass));
      check("err_count", 32'(s_err),  32'(m_err));
      check("fail_a",    32'(s_fa),   32'(m_fa));
      check("fail_b",    32'(s_fb),   32'(m_fb));
    end
  end

  // Counts edges after the current point until done is seen; -1 if the bound expires.
  task automatic wait_done(input bit mid, output int nd);
    int n;
    n  = 0;
    nd = -1;
    while (nd < 0 && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (mid && n == 9) start = 1'b1;
      if (mid && n == 10) start = 1'b0;
      if (s_done) nd = n;
    end
  endtask

  task automatic run(input bit mid, input bit hold, output int nd);
    @(negedge clk);
    start    = 1'b1;
    cm_clear = 1'b1;
    @(posedge clk);
    #1;
    cm_clear = 1'b0;
    if (!hold) start = 1'b0;
    wait_done(mid, nd);
  endtask

  task automatic rst_pulse(input int new_sel);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sel   = new_sel;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  int nd;
  int done_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_a",       32'(s_a),    32'd0);
    check("rst_busy",    32'(s_busy), 32'd0);
    check("rst_cmp_rst", 32'(s_cr),   32'd0);
    check("rst_err",     32'(s_err),  32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    mode0 = 0;
    run(1'b0, 1'b0, nd);
    check("good_done_at", 32'(nd), 32'd36);
    check("good_pass", 32'(s_pass), 32'd1);
    check("good_err", 32'(s_err), 32'd0);

    repeat (3) @(posedge clk);
    mode0 = 1;
    run(1'b0, 1'b0, nd);
    check("eqstuck_done_at", 32'(nd), 32'd36);
    check("eqstuck_err", 32'(s_err), 32'd4);
    check("eqstuck_pass", 32'(s_pass), 32'd0);
    check("eqstuck_fail_a", 32'(s_fa), 32'd0);
    check("eqstuck_fail_b", 32'(s_fb), 32'd0);

    repeat (3) @(posedge clk);
    mode0 = 2;
    run(1'b0, 1'b0, nd);
    check("norst_err", 32'(s_err), 32'd1);
    check("norst_pass", 32'(s_pass), 32'd0);
    check("norst_fail_b", 32'(s_fb), 32'd0);

    repeat (3) @(posedge clk);
    mode0 = 0;
    run(1'b1, 1'b0, nd);
    check("midstart_done_at", 32'(nd), 32'd36);
    check("midstart_pass", 32'(s_pass), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("midstart_no_rerun", 32'(s_busy), 32'd0);

    run(1'b0, 1'b1, nd);
    check("held_done_at", 32'(nd), 32'd36);
    @(posedge clk);
    #1;
    check("held_gap_busy", 32'(s_busy), 32'd0);
    @(posedge clk);
    #1;
    check("held_restart_busy", 32'(s_busy), 32'd1);
    check("held_restart_cmp_rst", 32'(s_cr), 32'd1);
    start = 1'b0;
    wait_done(1'b0, nd);
    check("held_second_done_at", 32'(nd), 32'd36);

    repeat (3) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    cm_clear = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cm_clear = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(s_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_a", 32'(s_a), 32'd0);
    check("abort_b", 32'(s_b), 32'd0);
    check("abort_busy", 32'(s_busy), 32'd0);
    check("abort_cmp_rst", 32'(s_cr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (s_done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run(1'b0, 1'b0, nd);
    check("abort_rerun_done_at", 32'(nd), 32'd36);
    check("abort_rerun_pass", 32'(s_pass), 32'd1);

    mode1 = 3;
    rst_pulse(1);
    run(1'b0, 1'b0, nd);
    check("lat2_done_at", 32'(nd), 32'd54);
    check("lat2_pass", 32'(s_pass), 32'd1);
    check("lat2_err", 32'(s_err), 32'd0);

    mode0 = 3;
    rst_pulse(0);
    run(1'b0, 1'b0, nd);
    check("lat_short_done_at", 32'(nd), 32'd36);
    check("lat_short_pass", 32'(s_pass), 32'd0);
    check("lat_short_err_nonzero", 32'(s_err != 6'd0), 32'd1);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_bist.md
# comparator_bist

Built-in self-test sequencer that drives the operand side of the registered 2-bit `comparator` block and checks its `A_gt_B_reg`/`A_eq_B_reg`/`A_lt_B_reg` result flags. On `start` it pulses the comparator's synchronous reset, sweeps every operand pair exhaustively and checks the registered flags against expected unsigned magnitude results. It then re-checks reset, and reports pass/fail, an error count and the first failing operand pair. It sits beside the comparator in silicon self-test and bring-up builds, in place of the simulation bench.

## Interface
- `WIDTH`, 2: operand width; must match the comparator.
- `RESULT_LATENCY`, 1: clock edges from the comparator sampling its inputs to its flags being valid; range 1..7.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low (asserted at 0).
- `start`  in  1  begin a test run; sampled only in IDLE.
- `A`  out  WIDTH  operand A to comparator (registered).
- `B`  out  WIDTH  operand B to comparator (registered).
- `cmp_rst`  out  1  active-high synchronous reset to comparator (registered).
- `A_gt_B_reg`, `A_eq_B_reg`, `A_lt_B_reg`  in  1 each  comparator result flags.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  last run had zero errors; held until next start.
- `err_count`  out  2*WIDTH+2  errors in current/last run; saturating.
- `fail_A`, `fail_B`  out  WIDTH each  operands of first failing pair; 0 if none or first failure was a reset check.

## Operation
- FSM states: IDLE, RST_STEP, PAIR_STEP, FINAL_RST_STEP, DONE.
- IDLE: `start`=1 at an edge -> RST_STEP. This clears `err_count`, `pass`, `fail_A` and `fail_B`, sets `busy`, and sets `cmp_rst`=1 and `A`=`B`=0.
- Each step is exactly RESULT_LATENCY+1 cycles, timed by a step counter.
  - `cmp_rst` is 1 only in the first cycle of a reset step.
  - Flags are sampled on the edge that ends the step.
- Reset check (RST_STEP, FINAL_RST_STEP): expected flags are all 0. Any nonzero flag is one error (+1 per step, not per flag).
- Pair check (PAIR_STEP): expected values are gt=(A>B), eq=(A==B), lt=(A<B), unsigned. Any mismatch in any flag is one error per pair.
- Sweep order: A outer and B inner, both 0..2^WIDTH-1 ascending. The next A/B are loaded on the same edge that samples the current pair.
- After pair (max,max) -> FINAL_RST_STEP. `A` and `B` hold max during this step.
- First error latches `fail_A`/`fail_B` (pair) or leaves them 0 (reset check). Later errors do not update them.
- `err_count` saturates at all-ones.
- DONE: one cycle. `done`=1, `busy`=0, `pass`=(`err_count`==0). Then -> IDLE.
- `start` is ignored while not in IDLE.

## Timing
- Reset (`rst`=0), asynchronous: state=IDLE; `A`=`B`=0; `cmp_rst`=0; `busy`=`done`=`pass`=0; `err_count`=0; `fail_A`=`fail_B`=0.
- Reset mid-run aborts immediately with no `done` pulse. The comparator is not reset by this block.
- `start` sampled at edge S gives these outputs after edge S: `cmp_rst`=1, `busy`=1.
- Step k (k=1..4^WIDTH+2) samples at edge S+k·(RESULT_LATENCY+1).
- Total run: N=(4^WIDTH+2)·(RESULT_LATENCY+1) cycles. Example: WIDTH=2, RESULT_LATENCY=1 gives N=36.
- After edge S+N: `done`=1 and `busy`=0 for one cycle; `pass` is valid.
- `start` held high continuously starts a new run on the edge after DONE, that is, IDLE's first edge.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Correct comparator model, WIDTH=2, RESULT_LATENCY=1, `start` pulsed at edge S -> `done` at edge S+36, `pass`=1, `err_count`=0, `fail_A`=`fail_B`=0.
- Model with `A_eq_B_reg` stuck at 0 -> `err_count`=4, `pass`=0, `fail_A`=0, `fail_B`=0 (first failing pair is (0,0)).
- Model that ignores `cmp_rst` (flags hold last result) -> the initial reset check passes (power-up flags 0) and FINAL_RST_STEP fails (eq=1 from the (3,3) pair). Result: `err_count`=1, `pass`=0, `fail_A`=`fail_B`=0.
- Model with 2-cycle output delay and RESULT_LATENCY=2 -> `done` at S+54, `pass`=1. The same model with RESULT_LATENCY=1 -> `pass`=0, `err_count`>0.
- Pulse `start` again at S+10 mid-run -> ignored; `done` still at S+36 only.
- Drive `rst`=0 asynchronously at S+15 -> all outputs 0 immediately, including `A`, `B` and `busy`. No `done` pulse follows. A new `start` runs a clean 36-cycle test.
